// File: rtl/uart_tx_module.sv
// 8N1/8N2 UART transmitter fed by a small byte FIFO; frames leave back-to-back.
// States: IDLE line high, wait for data | START start bit | DATA 8 data bits LSB first | STOP stop bit(s)
module uart_tx_module #(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk_input,
  input  logic                          rst_n,
  input  logic [31:0]                   baud_div,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_pin,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [31:0]   bdiv_q, bdiv_d;
  logic [31:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          stop_cnt_q, stop_cnt_d;
  logic          tx_pin_q, tx_pin_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop, fifo_empty, baud_tc, last_stop;

  assign fifo_empty = (level_q == '0);
  assign tx_ready   = (level_q != FULL);
  assign push       = tx_valid && tx_ready;
  assign baud_tc    = (baud_cnt_q == bdiv_q - 32'd1);
  assign last_stop  = (stop_cnt_q == STOP_LAST);
  assign tx_done    = (state_q == STOP) && baud_tc && last_stop;
  assign tx_busy    = (state_q != IDLE) || !fifo_empty;
  assign tx_pin     = tx_pin_q;
  assign fifo_level = level_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bdiv_d     = bdiv_q;
    baud_cnt_d = baud_cnt_q + 32'd1;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_pin_d   = tx_pin_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        tx_pin_d   = 1'b1;
        pop        = !fifo_empty;
      end
      START: begin
        if (baud_tc) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = DATA;
          tx_pin_d   = shift_q[0];
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
            tx_pin_d   = 1'b1;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_pin_d  = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_tc) begin
          baud_cnt_d = '0;
          if (last_stop) begin
            if (fifo_empty) state_d = IDLE;
            else            pop     = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A pop always starts a fresh frame, whether from IDLE or straight out of STOP.
    if (pop) begin
      state_d    = START;
      shift_d    = mem_q[rd_ptr_q];
      bdiv_d     = (baud_div < 32'd2) ? 32'd2 : baud_div;
      baud_cnt_d = '0;
      tx_pin_d   = 1'b0;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_input or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bdiv_q     <= 32'd2;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_pin_q   <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bdiv_q     <= bdiv_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_pin_q   <= tx_pin_d;
      level_q    <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_input) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_module.sv
// Directed bench for uart_tx_module: one instance with 1 stop bit, one with 2.
module tb_uart_tx_module;
  logic        clk_input = 1'b0;
  logic        rst_n;
  logic [31:0] baud_div;
  logic [7:0]  tx_data;
  logic        tx_valid1, tx_valid2;
  logic        ready1, ready2, pin1, pin2, busy1, busy2, done1, done2;
  logic [2:0]  level1, level2;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk_input = ~clk_input;

  uart_tx_module #(.FIFO_DEPTH(4), .STOP_BITS(1)) dut1 (
    .clk_input(clk_input), .rst_n(rst_n), .baud_div(baud_div), .tx_data(tx_data),
    .tx_valid(tx_valid1), .tx_ready(ready1), .tx_pin(pin1), .tx_busy(busy1),
    .tx_done(done1), .fifo_level(level1));

  uart_tx_module #(.FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk_input(clk_input), .rst_n(rst_n), .baud_div(baud_div), .tx_data(tx_data),
    .tx_valid(tx_valid2), .tx_ready(ready2), .tx_pin(pin2), .tx_busy(busy2),
    .tx_done(done2), .fifo_level(level2));

  task automatic tick();
    @(posedge clk_input);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write one byte into dut1 and advance to the first clock of its frame.
  task automatic send_one(input logic [7:0] b);
    tx_valid1 = 1'b1;
    tx_data   = b;
    tick();
    tx_valid1 = 1'b0;
    tick();
  endtask

  // Walk one frame clock by clock; optionally push a byte on the frame's last edge.
  task automatic frame(input int which, input logic [7:0] b, input int bdiv, input int stops,
                       input int skip, input bit push, input logic [7:0] pb);
    int    nb;
    int    total;
    int    idx;
    logic  e;
    nb    = 9 + stops;
    total = nb * bdiv;
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < bdiv; c++) begin
        idx = i * bdiv + c;
        if (idx >= skip) begin
          if (i == 0)      e = 1'b0;
          else if (i <= 8) e = b[i-1];
          else             e = 1'b1;
          chk($sformatf("pin%0d_b%0h_i%0d", which, b, idx), (which == 2) ? pin2 : pin1, e);
          chk($sformatf("done%0d_b%0h_i%0d", which, b, idx), (which == 2) ? done2 : done1,
              (idx == total - 1));
          if (push && idx == total - 1) begin
            tx_valid1 = 1'b1;
            tx_data   = pb;
          end
          tick();
          tx_valid1 = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    baud_div  = 32'd4;
    tx_data   = 8'h00;
    tx_valid1 = 1'b0;
    tx_valid2 = 1'b0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_pin",   pin1,   1'b1);
    chk("rst_done",  done1,  1'b0);
    chk("rst_busy",  busy1,  1'b0);
    chk("rst_level", level1, 3'd0);
    chk("rst_ready", ready1, 1'b1);
    chk("rst_pin2",  pin2,   1'b1);
    rst_n = 1'b1;
    tick();

    // T1: 0xA5 at baud 4
    tx_valid1 = 1'b1;
    tx_data   = 8'hA5;
    tick();
    tx_valid1 = 1'b0;
    chk("t1_level_q", level1, 3'd1);
    chk("t1_busy_q",  busy1,  1'b1);
    chk("t1_pin_q",   pin1,   1'b1);
    tick();
    chk("t1_level_pop", level1, 3'd0);
    frame(1, 8'hA5, 4, 1, 0, 1'b0, 8'h00);
    chk("t1_busy_end", busy1, 1'b0);
    chk("t1_pin_end",  pin1,  1'b1);

    // T2: divisor clamp
    baud_div = 32'd0;
    send_one(8'h00);
    frame(1, 8'h00, 2, 1, 0, 1'b0, 8'h00);
    baud_div = 32'd1;
    send_one(8'h00);
    frame(1, 8'h00, 2, 1, 0, 1'b0, 8'h00);
    chk("t2_busy_end", busy1, 1'b0);

    // T3: burst of 5 into depth 4, 6th write while full
    baud_div  = 32'd3;
    tx_valid1 = 1'b1;
    tx_data   = 8'h11;
    tick();
    tx_data = 8'h12;
    tick();
    chk("t3_level_e2", level1, 3'd1);
    chk("t3_pin_e2",   pin1,   1'b0);
    tx_data = 8'h13;
    tick();
    chk("t3_level_e3", level1, 3'd2);
    tx_data = 8'h14;
    tick();
    chk("t3_level_e4", level1, 3'd3);
    chk("t3_ready_e4", ready1, 1'b1);
    tx_data = 8'h15;
    tick();
    chk("t3_level_e5", level1, 3'd4);
    chk("t3_ready_e5", ready1, 1'b0);
    tx_data = 8'h16;
    tick();
    tx_valid1 = 1'b0;
    chk("t3_level_e6", level1, 3'd4);
    chk("t3_ready_e6", ready1, 1'b0);
    frame(1, 8'h11, 3, 1, 4, 1'b0, 8'h00);
    chk("t3_level_f2", level1, 3'd3);
    frame(1, 8'h12, 3, 1, 0, 1'b0, 8'h00);
    frame(1, 8'h13, 3, 1, 0, 1'b0, 8'h00);
    frame(1, 8'h14, 3, 1, 0, 1'b0, 8'h00);
    frame(1, 8'h15, 3, 1, 0, 1'b0, 8'h00);
    chk("t3_busy_end",  busy1,  1'b0);
    chk("t3_level_end", level1, 3'd0);

    // T6: push coincident with pop at level 2
    baud_div  = 32'd2;
    tx_valid1 = 1'b1;
    tx_data   = 8'hA1;
    tick();
    chk("t6_level_e1", level1, 3'd1);
    tx_data = 8'hB2;
    tick();
    chk("t6_level_e2", level1, 3'd1);
    tx_data = 8'hC4;
    tick();
    tx_valid1 = 1'b0;
    chk("t6_level_e3", level1, 3'd2);
    frame(1, 8'hA1, 2, 1, 1, 1'b1, 8'hD8);
    chk("t6_level_pp", level1, 3'd2);
    frame(1, 8'hB2, 2, 1, 0, 1'b0, 8'h00);
    frame(1, 8'hC4, 2, 1, 0, 1'b0, 8'h00);
    frame(1, 8'hD8, 2, 1, 0, 1'b0, 8'h00);
    chk("t6_busy_end", busy1, 1'b0);

    // T4: reset during data bit 3 of 0xC3 with 0x77 queued
    baud_div  = 32'd4;
    tx_valid1 = 1'b1;
    tx_data   = 8'hC3;
    tick();
    tx_data = 8'h77;
    tick();
    tx_valid1 = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    chk("t4_pin_bit3",  pin1,   1'b0);
    chk("t4_level_pre", level1, 3'd1);
    rst_n = 1'b0;
    #1;
    chk("t4_pin_rst",   pin1,   1'b1);
    chk("t4_level_rst", level1, 3'd0);
    chk("t4_busy_rst",  busy1,  1'b0);
    chk("t4_ready_rst", ready1, 1'b1);
    chk("t4_done_rst",  done1,  1'b0);
    tick();
    chk("t4_done_hold", done1, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("t4_done_post", done1, 1'b0);
    chk("t4_pin_post",  pin1,  1'b1);
    send_one(8'h96);
    frame(1, 8'h96, 4, 1, 0, 1'b0, 8'h00);
    chk("t4_busy_end", busy1, 1'b0);

    // T5: two stop bits, divisor change mid-frame
    baud_div  = 32'd8;
    tx_valid2 = 1'b1;
    tx_data   = 8'hFF;
    tick();
    tx_valid2 = 1'b0;
    chk("t5_level_q", level2, 3'd1);
    tick();
    chk("t5_pin_start", pin2, 1'b0);
    baud_div  = 32'd3;
    tx_valid2 = 1'b1;
    tx_data   = 8'h5A;
    tick();
    tx_valid2 = 1'b0;
    frame(2, 8'hFF, 8, 2, 1, 1'b0, 8'h00);
    frame(2, 8'h5A, 3, 2, 0, 1'b0, 8'h00);
    chk("t5_busy_end", busy2, 1'b0);
    chk("t5_pin_end",  pin2,  1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
